// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Boot-time writer for the instruction memory. Takes a byte stream with a
// 2-byte big-endian word-count header, packs bytes MSB-first into WIDTH-bit
// words and issues one write per word at incrementing addresses from 0.
// Words past VOLUME are drained from the stream but never written.

module instr_mem_loader #(
    parameter int WIDTH  = 32,
    parameter int VOLUME = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WIDTH-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BYTES  = WIDTH / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    // 17 bits so a VOLUME of 65536 still compares correctly against 16-bit counts
    localparam logic [16:0] VOL17 = 17'(VOLUME);

    typedef enum logic [1:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA
    } state_t;

    state_t              state;
    logic [15:0]         len;
    logic [15:0]         word_idx;
    logic [BCNT_W-1:0]   byte_cnt;
    logic [WIDTH-1:0]    word_reg;

    logic                accept;
    logic [WIDTH-1:0]    next_word;
    logic [15:0]         hdr_len;
    logic                word_last_byte;
    logic                in_range;
    logic                final_word;

    // Ready depends only on state, so the source never sees a ready that
    // combinationally depends on its own valid.
    assign byte_ready     = (state != IDLE);
    assign accept         = byte_valid && byte_ready;
    assign next_word      = (word_reg << 8) | WIDTH'(byte_data);
    // Full header count as it will be once the low byte is taken this cycle
    assign hdr_len        = {len[15:8], byte_data};
    assign word_last_byte = (byte_cnt == LAST_BYTE);
    assign in_range       = ({1'b0, word_idx} < VOL17);
    assign final_word     = ((word_idx + 16'd1) == len);

    // Load FSM: header capture, byte packing, write strobe and status flags
    always_ff @(posedge clk) begin
        // NOTE: every register here is plain state (no memory array), so all
        // of it is reset; a mid-load reset must also drop any partial word.
        if (!rst_n) begin
            state    <= IDLE;
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_reg <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; the strobe defaults low and is
            // raised only in the cycle a word completes, giving a 1-cycle pulse.
            wr_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LEN_HI;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        len      <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end

                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= byte_data;
                        state     <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= byte_data;
                        word_idx <= '0;
                        byte_cnt <= '0;
                        if (hdr_len == 16'd0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            if ({1'b0, hdr_len} > VOL17) begin
                                error <= 1'b1;
                            end
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        word_reg <= next_word;
                        if (word_last_byte) begin
                            byte_cnt <= '0;
                            word_idx <= word_idx + 16'd1;
                            // Overflow words are consumed but not written
                            if (in_range) begin
                                wr_en   <= 1'b1;
                                wr_addr <= word_idx[ADDR_W-1:0];
                                wr_data <= next_word;
                            end
                            if (final_word) begin
                                state <= IDLE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (WIDTH=32, VOLUME=64, ADDR_W=6).
// Inputs change and outputs are sampled on the falling edge.

module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    instr_mem_loader #(
        .WIDTH  (32),
        .VOLUME (64),
        .ADDR_W (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Count every write strobe, sampled shortly after the rising edge
    always @(posedge clk) begin
        #2;
        if (wr_en === 1'b1) wr_count++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (byte_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    // Sends one word MSB-first and checks the write that must follow it
    task automatic send_word(input logic [31:0] w, input logic exp_wr, input logic [5:0] addr,
                             input logic last, input logic gaps);
        for (int i = 0; i < 4; i++) begin
            if (gaps) idle_cycles($urandom_range(1, 3));
            send_byte(w[31-8*i -: 8]);
            if (i < 3) check("wr_en_mid_word", {31'd0, wr_en}, 32'd0);
        end
        check("wr_en", {31'd0, wr_en}, {31'd0, exp_wr});
        if (exp_wr) begin
            check("wr_addr", {26'd0, wr_addr}, {26'd0, addr});
            check("wr_data", wr_data, w);
        end
        check("done", {31'd0, done}, {31'd0, last});
        check("busy", {31'd0, busy}, {31'd0, !last});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        check({tag, "_wr_addr"},    {26'd0, wr_addr},    32'd0);
        check({tag, "_wr_data"},    wr_data,             32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_done"},       {31'd0, done},       32'd0);
        check({tag, "_error"},      {31'd0, error},      32'd0);
    endtask

    // Runs the three-word nominal program, with or without bubbles
    task automatic nominal_load(input logic gaps);
        int base;
        base = wr_count;
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ready_after_start", {31'd0, byte_ready}, 32'd1);
        send_header(16'h0003);
        check("error_nominal", {31'd0, error}, 32'd0);
        send_word(32'h12345678, 1'b1, 6'd0, 1'b0, gaps);
        send_word(32'h9ABCDEF0, 1'b1, 6'd1, 1'b0, gaps);
        send_word(32'h00000001, 1'b1, 6'd2, 1'b1, gaps);
        check("error_end", {31'd0, error}, 32'd0);
        idle_cycles(1);
        check("wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
        check("ready_after_done", {31'd0, byte_ready}, 32'd0);
        check("write_count_nominal", wr_count - base, 32'd3);
    endtask

    initial begin
        int base;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        idle_cycles(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Nominal back-to-back stream
        nominal_load(1'b0);

        // Same stream with bubbles between bytes
        idle_cycles(2);
        nominal_load(1'b1);

        // Empty program
        idle_cycles(2);
        base = wr_count;
        pulse_start();
        check("done_cleared_by_start", {31'd0, done}, 32'd0);
        send_header(16'h0000);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_busy", {31'd0, busy}, 32'd0);
        check("empty_ready", {31'd0, byte_ready}, 32'd0);
        idle_cycles(2);
        check("empty_ready_later", {31'd0, byte_ready}, 32'd0);
        check("empty_writes", wr_count - base, 32'd0);

        // Overflow: 66 words into a 64-word memory; stray start mid-load
        idle_cycles(2);
        base = wr_count;
        pulse_start();
        send_header(16'h0042);
        check("ovf_error", {31'd0, error}, 32'd1);
        for (int i = 0; i < 66; i++) begin
            if (i == 10) begin
                pulse_start();
                check("ovf_start_ignored_busy", {31'd0, busy}, 32'd1);
                check("ovf_start_ignored_error", {31'd0, error}, 32'd1);
            end
            send_word(32'hC0DE0000 | 32'(i), (i < 64), 6'(i), (i == 65), 1'b0);
        end
        check("ovf_error_end", {31'd0, error}, 32'd1);
        check("ovf_writes", wr_count - base, 32'd64);

        // Reset in the middle of a word
        idle_cycles(2);
        base = wr_count;
        pulse_start();
        send_header(16'h0002);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        idle_cycles(2);
        check("midreset_writes", wr_count - base, 32'd0);
        pulse_start();
        send_header(16'h0001);
        send_word(32'hCAFEBABE, 1'b1, 6'd0, 1'b1, 1'b0);
        check("midreset_reload_writes", wr_count - base, 32'd1);

        // Start pulsed during DATA of a two-word load
        idle_cycles(2);
        base = wr_count;
        pulse_start();
        send_header(16'h0002);
        send_word(32'hA1B2C3D4, 1'b1, 6'd0, 1'b0, 1'b0);
        send_byte(8'h55);
        pulse_start();
        check("data_start_busy", {31'd0, busy}, 32'd1);
        check("data_start_ready", {31'd0, byte_ready}, 32'd1);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        check("data_start_wr_en", {31'd0, wr_en}, 32'd1);
        check("data_start_addr", {26'd0, wr_addr}, 32'd1);
        check("data_start_data", wr_data, 32'h55667788);
        check("data_start_done", {31'd0, done}, 32'd1);
        check("data_start_writes", wr_count - base, 32'd2);

        idle_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
